// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam int unsigned LD_LAT_MAX = 3;
  localparam int unsigned BUB_W      = $clog2(LD_LAT_MAX + 1);

  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: counts cycles with i_en high, holds at all-ones.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_cnt <= '0;
    else if (i_en && (o_cnt != '1))
      o_cnt <= o_cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, memory freeze.
// Optional perf counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LD_LAT = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_is_load,
  input  logic             i_ex_insn_vld,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_stall,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_stall,
  output logic             o_mem_wb_flush,
  output logic [1:0]       o_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LD_LAT - 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic             hazard, in_wait, in_lu, freeze;

  always_comb begin
    hazard  = i_ex_insn_vld && i_ex_is_load && i_ex_rd_wren &&
              (i_ex_rd_addr != REG_ZERO) &&
              (src_match(i_id_rs1_used, i_id_rs1_addr, i_ex_rd_addr) ||
               src_match(i_id_rs2_used, i_id_rs2_addr, i_ex_rd_addr));
    in_wait = (state_q == MEM_WAIT);
    in_lu   = (state_q == LU_STALL);
    freeze  = in_wait || (i_mem_req && !i_mem_ack);
  end

  // Outputs: freeze > redirect > bubble; everything forced low during reset.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_mem_wb_flush = 1'b0;
    o_state        = i_reset ? RUN : state_q;
    if (!i_reset) begin
      if (freeze) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_stall = 1'b1;
        o_mem_wb_flush = 1'b1;
      end else if (i_ex_redirect) begin
        o_if_id_flush  = 1'b1;
        o_id_ex_flush  = 1'b1;
      end else if (in_lu || hazard) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_flush  = 1'b1;
      end
    end
  end

  // Bubble count survives a freeze untouched, so total bubbles stay LD_LAT.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    bub_d   = bub_q;
    if (in_wait) begin
      if (i_mem_ack)
        state_d = ret_q;
    end else if (freeze) begin
      state_d = MEM_WAIT;
      ret_d   = in_lu ? LU_STALL : RUN;
    end else if (i_ex_redirect) begin
      state_d = RUN;
      bub_d   = '0;
    end else if (in_lu) begin
      if (bub_q <= BUB_W'(1)) begin
        state_d = RUN;
        bub_d   = '0;
      end else begin
        bub_d   = bub_q - 1'b1;
      end
    end else begin
      state_d = RUN;
      if (hazard && (LD_LAT > 1)) begin
        state_d = LU_STALL;
        bub_d   = BUB_INIT;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (o_pc_stall),
    .o_cnt   (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (o_id_ex_flush || o_if_id_flush),
    .o_cnt   (flush_cnt)
  );

  always_comb begin
    o_stall_cnt = i_reset ? '0 : stall_cnt;
    o_flush_cnt = i_reset ? '0 : flush_cnt;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controllers (LD_LAT=1,2,3) share stimulus; each vector targets one.
module tb_pipe_hazard_ctrl;

  localparam int K_IDLE = 0, K_HZ = 1, K_HZ0 = 2, K_HZ_RED = 3, K_RED = 4, K_REQ = 5,
                 K_REQACK = 6, K_REQ_RED = 7, K_REQACK_RED = 8, K_RST = 9, K_RST_REQ = 10;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_BUB  = 7'b1100100;
  localparam logic [6:0] O_FRZ  = 7'b1101011;
  localparam logic [6:0] O_RED  = 7'b0010100;

  typedef struct {
    int         sel;
    logic [1:0] st;
    logic [6:0] o;
    logic       chk;
    logic [3:0] sc;
    logic [3:0] fc;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, wren = 1'b0, ld = 1'b0, vld = 1'b0;
  logic       redir = 1'b0, req = 1'b0, ack = 1'b0;

  logic [2:0] pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, memwb_fl;
  logic [2:0][1:0] st;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [2:0][3:0] scnt, fcnt;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_hazard_ctrl #(.LD_LAT(g + 1), .CNT_W(4)) u_dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_id_rs1_addr  (rs1),
      .i_id_rs2_addr  (rs2),
      .i_id_rs1_used  (u1),
      .i_id_rs2_used  (u2),
      .i_ex_rd_addr   (rd),
      .i_ex_rd_wren   (wren),
      .i_ex_is_load   (ld),
      .i_ex_insn_vld  (vld),
      .i_ex_redirect  (redir),
      .i_mem_req      (req),
      .i_mem_ack      (ack),
      .o_pc_stall     (pc_st[g]),
      .o_if_id_stall  (ifid_st[g]),
      .o_if_id_flush  (ifid_fl[g]),
      .o_id_ex_stall  (idex_st[g]),
      .o_id_ex_flush  (idex_fl[g]),
      .o_ex_mem_stall (exmem_st[g]),
      .o_mem_wb_flush (memwb_fl[g]),
      .o_state        (st[g])
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      ,
      .o_stall_cnt    (scnt[g]),
      .o_flush_cnt    (fcnt[g])
`endif
    );
  end

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  string scen = "";
  int    step_no = 0;

  function automatic logic [6:0] outs_of(input int s);
    return {pc_st[s], ifid_st[s], ifid_fl[s], idex_st[s], idex_fl[s], exmem_st[s], memwb_fl[s]};
  endfunction

  task automatic step(input int kind, input int sel, input logic [1:0] est, input logic [6:0] eo,
                      input logic chk, input logic [3:0] es, input logic [3:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0;
    wren = 1'b0; ld = 1'b0; vld = 1'b0; redir = 1'b0; req = 1'b0; ack = 1'b0;
    case (kind)
      K_HZ, K_HZ_RED: begin  // EX: lw x5 ; ID: add x6,x5,x1
        rs1 = 5'd5; rs2 = 5'd1; u1 = 1'b1; u2 = 1'b1;
        rd = 5'd5; wren = 1'b1; ld = 1'b1; vld = 1'b1;
        redir = (kind == K_HZ_RED);
      end
      K_HZ0: begin           // EX: lw x0 ; ID reads x0
        rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b1; u2 = 1'b1;
        rd = 5'd0; wren = 1'b1; ld = 1'b1; vld = 1'b1;
      end
      K_RED:        redir = 1'b1;
      K_REQ:        req = 1'b1;
      K_REQACK:     begin req = 1'b1; ack = 1'b1; end
      K_REQ_RED:    begin req = 1'b1; redir = 1'b1; end
      K_REQACK_RED: begin req = 1'b1; ack = 1'b1; redir = 1'b1; end
      K_RST:        rst = 1'b1;
      K_RST_REQ:    begin rst = 1'b1; req = 1'b1; end
      default: ;
    endcase
    e.sel = sel; e.st = est; e.o = eo; e.chk = chk; e.sc = es; e.fc = ef;
    e.tag = $sformatf("%s[%0d]", scen, step_no);
    step_no++;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (st[e.sel] !== e.st) begin
          failures++;
          $display("FAIL %s o_state: got %0d expected %0d", e.tag, st[e.sel], e.st);
        end
        checks++;
        if (outs_of(e.sel) !== e.o) begin
          failures++;
          $display("FAIL %s outputs: got %b expected %b", e.tag, outs_of(e.sel), e.o);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        if (e.chk) begin
          checks++;
          if (scnt[e.sel] !== e.sc) begin
            failures++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, scnt[e.sel], e.sc);
          end
          checks++;
          if (fcnt[e.sel] !== e.fc) begin
            failures++;
            $display("FAIL %s flush_cnt: got %0d expected %0d", e.tag, fcnt[e.sel], e.fc);
          end
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // LD_LAT=1: single bubble, state stays RUN
    scen = "lat1"; step_no = 0;
    step(K_RST,  0, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    step(K_IDLE, 0, 2'd0, O_NONE, 1'b0, 4'd0, 4'd0);
    step(K_HZ,   0, 2'd0, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_IDLE, 0, 2'd0, O_NONE, 1'b1, 4'd1, 4'd1);

    // LD_LAT=3: three bubbles, state 0->1->1->0
    scen = "lat3"; step_no = 0;
    step(K_RST,  2, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    step(K_HZ,   2, 2'd0, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_IDLE, 2, 2'd1, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_IDLE, 2, 2'd1, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_IDLE, 2, 2'd0, O_NONE, 1'b1, 4'd3, 4'd3);

    // LD_LAT=2: bubble, 4+1 frozen cycles, remaining bubble
    scen = "lat2frz"; step_no = 0;
    step(K_RST,    1, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    step(K_HZ,     1, 2'd0, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_REQ,    1, 2'd1, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_REQ,    1, 2'd2, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_REQ,    1, 2'd2, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_REQ,    1, 2'd2, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_REQACK, 1, 2'd2, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_IDLE,   1, 2'd1, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_IDLE,   1, 2'd0, O_NONE, 1'b1, 4'd7, 4'd2);

    // x0 load, redirect priority, single-cycle access, freeze over redirect
    scen = "prio"; step_no = 0;
    step(K_RST,        1, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    step(K_HZ0,        1, 2'd0, O_NONE, 1'b0, 4'd0, 4'd0);
    step(K_HZ_RED,     1, 2'd0, O_RED,  1'b0, 4'd0, 4'd0);
    step(K_IDLE,       1, 2'd0, O_NONE, 1'b0, 4'd0, 4'd0);
    step(K_HZ,         1, 2'd0, O_BUB,  1'b0, 4'd0, 4'd0);
    step(K_RED,        1, 2'd1, O_RED,  1'b0, 4'd0, 4'd0);
    step(K_IDLE,       1, 2'd0, O_NONE, 1'b1, 4'd1, 4'd3);
    step(K_REQACK,     1, 2'd0, O_NONE, 1'b0, 4'd0, 4'd0);
    step(K_IDLE,       1, 2'd0, O_NONE, 1'b1, 4'd1, 4'd3);
    step(K_REQ_RED,    1, 2'd0, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_REQACK_RED, 1, 2'd2, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_IDLE,       1, 2'd0, O_NONE, 1'b1, 4'd3, 4'd3);

    // reset in the middle of MEM_WAIT
    scen = "rstwait"; step_no = 0;
    step(K_RST,     0, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    step(K_REQ,     0, 2'd0, O_FRZ,  1'b0, 4'd0, 4'd0);
    step(K_REQ,     0, 2'd2, O_FRZ,  1'b1, 4'd1, 4'd0);
    step(K_RST_REQ, 0, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    step(K_IDLE,    0, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);

    // 20+ stall cycles saturate a 4-bit counter at 4'hF
    scen = "sat"; step_no = 0;
    step(K_RST, 0, 2'd0, O_NONE, 1'b1, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++)
      step(K_REQ, 0, (i == 0) ? 2'd0 : 2'd2, O_FRZ, (i >= 14),
           (i >= 15) ? 4'hF : 4'(i), 4'd0);
    step(K_REQACK, 0, 2'd2, O_FRZ,  1'b1, 4'hF, 4'd0);
    step(K_IDLE,   0, 2'd0, O_NONE, 1'b1, 4'hF, 4'd0);

    repeat (3) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
